// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame-buffer constants, colours and writer state encoding
package vga_pkg;

    // Default frame geometry and coordinate width (2**CW_DEF covers both axes).
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int CW_DEF    = 10;

    // RGB565 colour constants.
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    // Pixel writer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/vga_drawmod_if.sv
// rtl/vga_drawmod_if.sv - command, flow-control and pixel-write bundle of the frame writer
//   iStart/iAbort          : command strobe and frame cancel
//   iX0/iY0/iX1/iY1        : rectangle corners (any order)
//   iFg/iBg                : foreground / background RGB565
//   iReady                 : frame buffer can take a write this cycle
//   oEn/oData              : pixel write strobe and data
//   oBusy/oDone            : frame in progress / one-cycle completion pulse
interface vga_drawmod_if
    import vga_pkg::*;
#(
    parameter int CW = CW_DEF
) ();

    logic          iStart;
    logic          iAbort;
    logic [CW-1:0] iX0;
    logic [CW-1:0] iY0;
    logic [CW-1:0] iX1;
    logic [CW-1:0] iY1;
    logic [15:0]   iFg;
    logic [15:0]   iBg;
    logic          iReady;
    logic          oEn;
    logic [15:0]   oData;
    logic          oBusy;
    logic          oDone;

    // Master is the environment around the writer: control logic issuing
    // commands plus the buffer reporting readiness and taking the writes.
    modport master (
        output iStart, iAbort, iX0, iY0, iX1, iY1, iFg, iBg, iReady,
        input  oEn, oData, oBusy, oDone
    );

    modport slave (
        input  iStart, iAbort, iX0, iY0, iX1, iY1, iFg, iBg, iReady,
        output oEn, oData, oBusy, oDone
    );

endinterface

// File: rtl/vga_rectcmp.sv
// rtl/vga_rectcmp.sv - combinational test of a pixel position against an inclusive rectangle
//   i_col/i_row : pixel position
//   i_xl/i_xh   : inclusive column bounds, i_xl <= i_xh
//   i_yl/i_yh   : inclusive row bounds, i_yl <= i_yh
//   o_inside    : position lies inside the rectangle
module vga_rectcmp #(
    parameter int CW = 10
) (
    input  logic [CW-1:0] i_col,
    input  logic [CW-1:0] i_row,
    input  logic [CW-1:0] i_xl,
    input  logic [CW-1:0] i_xh,
    input  logic [CW-1:0] i_yl,
    input  logic [CW-1:0] i_yh,
    output logic          o_inside
);

    logic w_in_x;
    logic w_in_y;

    assign w_in_x   = (i_col >= i_xl) && (i_col <= i_xh);
    assign w_in_y   = (i_row >= i_yl) && (i_row <= i_yh);
    assign o_inside = w_in_x && w_in_y;

endmodule

// File: rtl/vga_drawmod.sv
// rtl/vga_drawmod.sv - rectangle-fill frame writer streaming RGB565 pixels in raster order
//   CLOCK : write-side clock
//   RESET : asynchronous active-high reset
//   bus   : command inputs, buffer ready, pixel write strobe/data, busy/done status
module vga_drawmod
    import vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic          CLOCK,
    input  logic          RESET,
    vga_drawmod_if.slave  bus
);

    localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(V_RES - 1);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_xl;
    logic [CW-1:0] r_xh;
    logic [CW-1:0] r_yl;
    logic [CW-1:0] r_yh;
    logic [15:0]   r_fg;
    logic [15:0]   r_bg;
    logic [15:0]   r_data;
    logic          r_en;
    logic          r_busy;
    logic          r_done;

    logic          w_inside;
    logic          w_col_last;
    logic          w_row_last;

    vga_rectcmp #(.CW(CW)) u_rectcmp (
        .i_col    (r_col),
        .i_row    (r_row),
        .i_xl     (r_xl),
        .i_xh     (r_xh),
        .i_yl     (r_yl),
        .i_yh     (r_yh),
        .o_inside (w_inside)
    );

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_xl    <= '0;
            r_xh    <= '0;
            r_yl    <= '0;
            r_yh    <= '0;
            r_fg    <= '0;
            r_bg    <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below; r_data holds.
            r_en   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.iStart) begin
                        // Normalise corners so the comparator sees low <= high.
                        r_xl    <= (bus.iX0 < bus.iX1) ? bus.iX0 : bus.iX1;
                        r_xh    <= (bus.iX0 < bus.iX1) ? bus.iX1 : bus.iX0;
                        r_yl    <= (bus.iY0 < bus.iY1) ? bus.iY0 : bus.iY1;
                        r_yh    <= (bus.iY0 < bus.iY1) ? bus.iY1 : bus.iY0;
                        r_fg    <= bus.iFg;
                        r_bg    <= bus.iBg;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.iAbort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (bus.iReady) begin
                        r_en   <= 1'b1;
                        r_data <= w_inside ? r_fg : r_bg;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= DONE;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The final pixel's strobe is visible during this state;
                    // completion is reported one cycle later unless aborted.
                    r_busy  <= 1'b0;
                    r_done  <= !bus.iAbort;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oEn   = r_en;
    assign bus.oData = r_data;
    assign bus.oBusy = r_busy;
    assign bus.oDone = r_done;

endmodule

// File: tb/tb_vga_drawmod.sv
// tb/tb_vga_drawmod.sv - directed self-checking bench for the rectangle-fill frame writer
module tb_vga_drawmod;
    import vga_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 10;
    localparam int N  = H * V;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_drawmod_if #(.CW(CW)) bus ();

    vga_drawmod #(.H_RES(H), .V_RES(V), .CW(CW)) u_dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] pix[$];
    logic [15:0] ref_pix[$];
    int n_en, first_en, last_en, done_cyc, done_count;
    int ready_viol, busy_err, abort_cyc, busy_after_abort;

    function automatic logic [15:0] exp_pix(input int idx, input int x0, input int y0,
                                            input int x1, input int y1,
                                            input logic [15:0] fg, input logic [15:0] bg);
        int c, r, xl, xh, yl, yh;
        c  = idx % H;
        r  = idx / H;
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        return (c >= xl && c <= xh && r >= yl && r <= yh) ? fg : bg;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endfunction

    function automatic logic [15:0] pix_at(input int i);
        logic [15:0] v;
        v = 16'hxxxx;
        if (i < pix.size()) v = pix[i];
        return v;
    endfunction

    // Issues one command at cycle 0 and records the strobe stream and status
    // timing, with cycle numbers counted in clocks after the iStart cycle.
    task automatic run_frame(input int x0, input int y0, input int x1, input int y1,
                             input logic [15:0] fg, input logic [15:0] bg,
                             input int mode, input int restart_at,
                             input int abort_after, input int limit);
        logic prev_ready;
        logic [CW-1:0] tmp;
        pix.delete();
        n_en = 0; first_en = -1; last_en = -1; done_cyc = -1; done_count = 0;
        ready_viol = 0; busy_err = 0; abort_cyc = -1; busy_after_abort = -1;
        @(negedge clk);
        tmp = x0[CW-1:0]; bus.iX0 = tmp;
        tmp = y0[CW-1:0]; bus.iY0 = tmp;
        tmp = x1[CW-1:0]; bus.iX1 = tmp;
        tmp = y1[CW-1:0]; bus.iY1 = tmp;
        bus.iFg    = fg;
        bus.iBg    = bg;
        bus.iStart = 1'b1;
        bus.iAbort = 1'b0;
        bus.iReady = ready_for(mode, 0);
        prev_ready = bus.iReady;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (bus.oEn) begin
                pix.push_back(bus.oData);
                n_en++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                if (!prev_ready) ready_viol++;
            end
            if (bus.oDone) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) busy_after_abort = int'(bus.oBusy);
            if (abort_cyc < 0 && done_cyc < 0 && !bus.oBusy) busy_err++;
            bus.iStart = (restart_at > 0 && cyc == restart_at);
            if (restart_at > 0 && cyc >= restart_at) begin
                bus.iFg = GREEN;
                bus.iX0 = '0;
            end
            bus.iAbort = 1'b0;
            if (abort_after > 0 && abort_cyc < 0 && n_en == abort_after) begin
                bus.iAbort = 1'b1;
                abort_cyc  = cyc;
            end
            bus.iReady = ready_for(mode, cyc);
            prev_ready = bus.iReady;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (abort_cyc >= 0 && cyc >= abort_cyc + 20) break;
        end
        bus.iStart = 1'b0;
        bus.iAbort = 1'b0;
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iReady = 1'b0;
        bus.iX0 = '0; bus.iY0 = '0; bus.iX1 = '0; bus.iY1 = '0;
        bus.iFg = '0; bus.iBg = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.oEn !== 1'b0) begin errors++; $display("FAIL reset_oEn got=%b exp=0", bus.oEn); end
        checks++; if (bus.oData !== 16'h0000) begin errors++; $display("FAIL reset_oData got=%h exp=0000", bus.oData); end
        checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_oBusy got=%b exp=0", bus.oBusy); end
        checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL reset_oDone got=%b exp=0", bus.oDone); end
        rst = 1'b0;
        // Abort in IDLE with the buffer ready must not start anything.
        bus.iAbort = 1'b1; bus.iReady = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.oEn !== 1'b0 || bus.oBusy !== 1'b0) begin
                errors++; $display("FAIL idle_quiet got en=%b busy=%b exp en=0 busy=0", bus.oEn, bus.oBusy);
            end
        end
        bus.iAbort = 1'b0; bus.iReady = 1'b0;
    endtask

    task automatic test_basic();
        run_frame(2, 1, 4, 2, RED, BLUE, 0, 0, 0, 100);
        checks++; if (n_en !== 32) begin errors++; $display("FAIL basic_count got=%0d exp=32", n_en); end
        checks++; if (first_en !== 2) begin errors++; $display("FAIL basic_first_en got=%0d exp=2", first_en); end
        checks++; if (last_en !== 33) begin errors++; $display("FAIL basic_last_en got=%0d exp=33", last_en); end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=34", done_cyc); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_count); end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL basic_busy_gap got=%0d exp=0", busy_err); end
        checks++; if (pix_at(9) !== 16'h001F) begin errors++; $display("FAIL basic_pix9 got=%h exp=001f", pix_at(9)); end
        checks++; if (pix_at(10) !== 16'hF800) begin errors++; $display("FAIL basic_pix10 got=%h exp=f800", pix_at(10)); end
        checks++; if (pix_at(12) !== 16'hF800) begin errors++; $display("FAIL basic_pix12 got=%h exp=f800", pix_at(12)); end
        checks++; if (pix_at(13) !== 16'h001F) begin errors++; $display("FAIL basic_pix13 got=%h exp=001f", pix_at(13)); end
        checks++; if (pix_at(18) !== 16'hF800) begin errors++; $display("FAIL basic_pix18 got=%h exp=f800", pix_at(18)); end
        checks++; if (pix_at(20) !== 16'hF800) begin errors++; $display("FAIL basic_pix20 got=%h exp=f800", pix_at(20)); end
        checks++; if (pix_at(21) !== 16'h001F) begin errors++; $display("FAIL basic_pix21 got=%h exp=001f", pix_at(21)); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_at(i) !== exp_pix(i, 2, 1, 4, 2, RED, BLUE)) begin
                errors++; $display("FAIL basic_stream idx=%0d got=%h exp=%h", i, pix_at(i), exp_pix(i, 2, 1, 4, 2, RED, BLUE));
            end
        end
        ref_pix.delete();
        for (int i = 0; i < N; i++) ref_pix.push_back(exp_pix(i, 2, 1, 4, 2, RED, BLUE));
    endtask

    task automatic test_swapped();
        run_frame(4, 2, 2, 1, RED, BLUE, 0, 0, 0, 100);
        checks++; if (n_en !== 32) begin errors++; $display("FAIL swap_count got=%0d exp=32", n_en); end
        checks++; if (first_en !== 2) begin errors++; $display("FAIL swap_first_en got=%0d exp=2", first_en); end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL swap_done_cycle got=%0d exp=34", done_cyc); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_at(i) !== ref_pix[i]) begin
                errors++; $display("FAIL swap_stream idx=%0d got=%h exp=%h", i, pix_at(i), ref_pix[i]);
            end
        end
    endtask

    task automatic test_ready_toggle();
        run_frame(2, 1, 4, 2, RED, BLUE, 1, 0, 0, 200);
        checks++; if (n_en !== 32) begin errors++; $display("FAIL toggle_count got=%0d exp=32", n_en); end
        checks++; if (ready_viol !== 0) begin errors++; $display("FAIL toggle_en_after_not_ready got=%0d exp=0", ready_viol); end
        checks++; if (busy_err !== 0) begin errors++; $display("FAIL toggle_busy_gap got=%0d exp=0", busy_err); end
        checks++; if (done_count !== 1) begin errors++; $display("FAIL toggle_done_count got=%0d exp=1", done_count); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_at(i) !== ref_pix[i]) begin
                errors++; $display("FAIL toggle_stream idx=%0d got=%h exp=%h", i, pix_at(i), ref_pix[i]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        run_frame(2, 1, 4, 2, RED, BLUE, 0, 5, 0, 100);
        checks++; if (n_en !== 32) begin errors++; $display("FAIL restart_count got=%0d exp=32", n_en); end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL restart_done_cycle got=%0d exp=34", done_cyc); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (pix_at(i) !== ref_pix[i]) begin
                errors++; $display("FAIL restart_stream idx=%0d got=%h exp=%h", i, pix_at(i), ref_pix[i]);
            end
        end
        run_frame(2, 1, 4, 2, GREEN, BLACK, 0, 0, 0, 100);
        checks++; if (n_en !== 32) begin errors++; $display("FAIL newcmd_count got=%0d exp=32", n_en); end
        checks++; if (pix_at(0) !== 16'h0000) begin errors++; $display("FAIL newcmd_pix0 got=%h exp=0000", pix_at(0)); end
        checks++; if (pix_at(10) !== 16'h07E0) begin errors++; $display("FAIL newcmd_pix10 got=%h exp=07e0", pix_at(10)); end
        checks++; if (pix_at(20) !== 16'h07E0) begin errors++; $display("FAIL newcmd_pix20 got=%h exp=07e0", pix_at(20)); end
    endtask

    task automatic test_abort();
        run_frame(2, 1, 4, 2, RED, BLUE, 0, 0, 10, 100);
        checks++; if (abort_cyc < 0) begin errors++; $display("FAIL abort_reached got=%0d exp=>=0", abort_cyc); end
        checks++; if (n_en !== 10) begin errors++; $display("FAIL abort_count got=%0d exp=10", n_en); end
        checks++; if (busy_after_abort !== 0) begin errors++; $display("FAIL abort_busy got=%0d exp=0", busy_after_abort); end
        checks++; if (done_count !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_count); end
        run_frame(0, 0, 1, 0, WHITE, BLACK, 0, 0, 0, 100);
        checks++; if (first_en !== 2) begin errors++; $display("FAIL rerun_first_en got=%0d exp=2", first_en); end
        checks++; if (n_en !== 32) begin errors++; $display("FAIL rerun_count got=%0d exp=32", n_en); end
        checks++; if (pix_at(0) !== 16'hFFFF) begin errors++; $display("FAIL rerun_pix0 got=%h exp=ffff", pix_at(0)); end
        checks++; if (pix_at(1) !== 16'hFFFF) begin errors++; $display("FAIL rerun_pix1 got=%h exp=ffff", pix_at(1)); end
        checks++; if (pix_at(2) !== 16'h0000) begin errors++; $display("FAIL rerun_pix2 got=%h exp=0000", pix_at(2)); end
        checks++; if (done_cyc !== 34) begin errors++; $display("FAIL rerun_done_cycle got=%0d exp=34", done_cyc); end
    endtask

    task automatic test_async_reset();
        int stray;
        @(negedge clk);
        bus.iX0 = 10'd2; bus.iY0 = 10'd1; bus.iX1 = 10'd4; bus.iY1 = 10'd2;
        bus.iFg = RED; bus.iBg = BLUE;
        bus.iStart = 1'b1; bus.iReady = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        checks++; if (bus.oEn !== 1'b1) begin errors++; $display("FAIL arst_pre_en got=%b exp=1", bus.oEn); end
        rst = 1'b1;
        #1;
        checks++; if (bus.oEn !== 1'b0) begin errors++; $display("FAIL arst_oEn got=%b exp=0", bus.oEn); end
        checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL arst_oBusy got=%b exp=0", bus.oBusy); end
        checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL arst_oDone got=%b exp=0", bus.oDone); end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.oEn || bus.oBusy || bus.oDone) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL arst_idle_after got=%0d exp=0", stray); end
        run_frame(2, 1, 4, 2, RED, BLUE, 0, 0, 0, 100);
        checks++; if (first_en !== 2) begin errors++; $display("FAIL arst_rerun_first got=%0d exp=2", first_en); end
        checks++; if (n_en !== 32) begin errors++; $display("FAIL arst_rerun_count got=%0d exp=32", n_en); end
        checks++; if (pix_at(10) !== 16'hF800) begin errors++; $display("FAIL arst_rerun_pix10 got=%h exp=f800", pix_at(10)); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_swapped();
        test_ready_toggle();
        test_restart_ignored();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_drawmod.md
Name: vga_drawmod

Overview:
- Pixel writer (producer end) for the VGA frame-buffer save path.
- Accepts one rectangle-fill command and streams a full frame of RGB565 pixels, in raster order, as sequential write strobes (oEn/oData). These drive the buffer's write enable and write data.
- Pixels inside the rectangle get the foreground colour; all others get the background colour.
- Sits between the graphics control logic and the frame-buffer write port. Runs in the write-side (100 MHz) domain.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- CW, 10, coordinate width; must satisfy 2^CW >= max(H_RES, V_RES).

Ports:
- CLOCK  in  1  write-side clock.
- RESET  in  1  asynchronous, active-high reset.
- iStart  in  1  command strobe; sampled only in IDLE.
- iAbort  in  1  cancel the current frame.
- iX0  in  CW  rectangle corner A, column.
- iY0  in  CW  rectangle corner A, row.
- iX1  in  CW  rectangle corner B, column.
- iY1  in  CW  rectangle corner B, row.
- iFg  in  16  foreground RGB565.
- iBg  in  16  background RGB565.
- iReady  in  1  buffer can accept a write this cycle.
- oEn  out  1  write strobe, one pixel per high cycle.
- oData  out  16  pixel data, valid when oEn=1.
- oBusy  out  1  a frame is in progress.
- oDone  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Clock and reset: one clock, CLOCK. RESET is asynchronous and active-high.
  - While RESET=1: state=IDLE, col=0, row=0; oEn=0, oData=0, oBusy=0, oDone=0; latched command registers cleared.
- States: IDLE -> STREAM -> DONE -> IDLE.
- IDLE:
  - On iStart=1, latch xl=min(iX0,iX1), xh=max(iX0,iX1), yl=min(iY0,iY1), yh=max(iY0,iY1), fg, bg.
  - Clear col and row, go to STREAM. oBusy goes high the next cycle.
- STREAM:
  - In each cycle with iReady=1:
    - The next cycle has oEn=1 and oData = fg if (xl<=col<=xh && yl<=row<=yh), else bg.
    - col increments. At col=H_RES-1, col wraps to 0 and row increments.
  - In a cycle with iReady=0: the next cycle has oEn=0. Counters and oData hold.
  - The write of pixel (H_RES-1, V_RES-1) moves the state to DONE.
  - Exactly H_RES*V_RES strobes are issued per frame.
  - Latency: one cycle from an accepted iReady to the corresponding oEn.
- DONE:
  - oDone=1 for one cycle, oBusy drops in the same cycle, return to IDLE.
  - The first oEn of a frame lags iStart by 2 cycles when iReady=1 throughout.
  - With iReady=1 throughout, oDone is high at cycle H_RES*V_RES+2 after iStart.
- Boundary conditions:
  - Rectangle coordinates >= H_RES or V_RES are clipped naturally: such pixels never occur.
  - A zero-area rectangle is impossible; x0=x1 gives a 1-pixel-wide column.
  - iStart outside IDLE is ignored; the latched command stays stable for the whole frame.
  - iAbort=1 in STREAM or DONE: next cycle state=IDLE, oEn=0, oBusy=0, no oDone. iAbort has priority over iStart in the same cycle.
  - iAbort in IDLE has no effect.
  - RESET mid-frame: immediate return to reset values, no partial oDone.
  - oData holds its last value when oEn=0; consumers must qualify it with oEn.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES/V_RES defaults.
  - CW.
  - RGB565 colour constants (BLACK=16'h0000, WHITE=16'hFFFF, RED=16'hF800, GREEN=16'h07E0, BLUE=16'h001F).
  - State encoding (IDLE=2'd0, STREAM=2'd1, DONE=2'd2).
- Sub-module vga_rectcmp is natural: combinational inside-test of (col,row) against (xl,xh,yl,yh). It is reusable by later sprite or overlay writers.
- The top FSM and counters stay in vga_drawmod.

Test Plan:
1. H_RES=8, V_RES=4; reset released; iStart with (x0,y0,x1,y1)=(2,1,4,2), fg=F800, bg=001F; iReady=1.
   - Required: 32 oEn pulses on contiguous cycles, first at iStart+2.
   - Required: pixel indices 10-12 and 18-20 are F800, all others 001F.
   - Required: oDone at cycle 34 after iStart.
2. Same command with corners swapped, (4,2,2,1).
   - Required: stream identical to scenario 1.
3. iReady toggled 1,0,0,1 repeatedly.
   - Required: still exactly 32 strobes in identical pixel order.
   - Required: no oEn in the cycle after any iReady=0.
   - Required: oBusy stays high until oDone.
4. iStart pulsed again mid-frame with fg=07E0.
   - Required: ignored; the frame still uses F800.
   - Required: afterwards, a new iStart is accepted and the next frame uses the new colours.
5. iAbort asserted after 10 strobes.
   - Required: no further oEn, oBusy=0 the next cycle, oDone never pulses.
   - Required: a subsequent iStart restarts from pixel (0,0).
6. RESET asserted asynchronously mid-frame, between clock edges.
   - Required: oEn, oBusy and oDone go to 0 immediately.
   - Required: after release, the block is idle until iStart.
